// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline sequencing for the 5-stage core. Produces the register-enable,
// bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM from the decoded
// fields of the instructions currently in ID, EX and MEM.
//
//   - load-use hazard (load in EX, consumer in ID)  -> 1-cycle stall
//   - jr source hazard (producer in EX or MEM)      -> stall until clear
//   - branch taken, resolved in MEM                 -> flush IF/ID, ID/EX, EX/MEM
//   - multi-cycle mult/div in EX                    -> hold front end, bubble EX/MEM
//
// All control outputs are combinational from the FSM state and the inputs.
// Only the FSM state, the mult/div occupancy counter and the stall counter
// are registered.
//
// Ports
//   Clk           clock, every state update on the rising edge
//   Rst           synchronous active-high reset
//   rs_ID         rs field of the instruction in ID
//   rt_ID         rt field of the instruction in ID
//   UsesRt_ID     ID instruction reads rt as a source
//   JR_ID         ID instruction is jr
//   MulDiv_ID     ID instruction is mult/div
//   MemRead_IDEX  instruction in EX is a load
//   rt_IDEX       load destination in EX
//   RegWrite_EX   EX instruction writes a register
//   WriteReg_EX   EX destination register
//   RegWrite_MEM  MEM instruction writes a register
//   WriteReg_MEM  MEM destination register
//   PCSrc_MEM     branch taken, resolved in MEM
//   PCWrite       PC load enable
//   IFIDWrite     IF/ID load enable
//   IDEXWrite     ID/EX load enable
//   IDEX_Bubble   load zeroed controls into ID/EX (hazard stall)
//   IFID_Flush    load NOP into IF/ID
//   IDEX_Flush    load zeroed controls into ID/EX (branch flush)
//   EXMEM_Bubble  load zeroed controls into EX/MEM
//   MulDivBusy    FSM is in the MULDIV state
//   StallCount    saturating count of cycles with PCWrite=0
//
// State table
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_RUN    | normal flow; hazards and branch flushes evaluated each cycle
//   ST_MULDIV | mult/div held in ID/EX; front end frozen until counter hits 0
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MULDIV_LAT  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [4:0]             rs_ID,
  input  logic [4:0]             rt_ID,
  input  logic                   UsesRt_ID,
  input  logic                   JR_ID,
  input  logic                   MulDiv_ID,
  input  logic                   MemRead_IDEX,
  input  logic [4:0]             rt_IDEX,
  input  logic                   RegWrite_EX,
  input  logic [4:0]             WriteReg_EX,
  input  logic                   RegWrite_MEM,
  input  logic [4:0]             WriteReg_MEM,
  input  logic                   PCSrc_MEM,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IDEXWrite,
  output logic                   IDEX_Bubble,
  output logic                   IFID_Flush,
  output logic                   IDEX_Flush,
  output logic                   EXMEM_Bubble,
  output logic                   MulDivBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  // The counter only ever holds values up to MULDIV_LAT-2; keep it at least
  // one bit wide so small latencies still elaborate cleanly.
  localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MULDIV_LAT >= 2) ? (MULDIV_LAT - 2) : 0);
  localparam bit MULDIV_MULTI = (MULDIV_LAT > 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] busy_cnt_nxt;

  logic             load_use;
  logic             jr_hazard;
  logic             stall_sat;

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  // A load into $0 never creates a dependency, hence the rt_IDEX != 0 guard.
  assign load_use = MemRead_IDEX && (rt_IDEX != 5'd0) &&
                    ((rt_IDEX == rs_ID) || (UsesRt_ID && (rt_IDEX == rt_ID)));

  // jr reads rs in ID, so it must wait for any producer still in EX or MEM.
  // Naturally lasts up to two cycles as the producer walks EX -> MEM -> WB.
  assign jr_hazard = JR_ID && (rs_ID != 5'd0) &&
                     ((RegWrite_EX  && (WriteReg_EX  == rs_ID)) ||
                      (RegWrite_MEM && (WriteReg_MEM == rs_ID)));

  assign stall_sat = &StallCount;

  // ---------------------------------------------------------------------------
  // Control outputs and next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    IDEX_Bubble  = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulDivBusy   = 1'b0;
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;

    if (Rst) begin
      // Outputs stay at their pass-through values while reset is held.
      state_nxt    = ST_RUN;
      busy_cnt_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (PCSrc_MEM) begin
            // Everything younger than the branch is wrong-path, including a
            // mult/div sitting in ID, so it must not start the MULDIV hold.
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            EXMEM_Bubble = 1'b1;
          end else if (load_use || jr_hazard) begin
            // Freeze PC and IF/ID; ID/EX still loads, but it loads a bubble.
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (MulDiv_ID && MULDIV_MULTI) begin
            // The mult/div advances into EX this cycle; the hold starts next.
            state_nxt    = ST_MULDIV;
            busy_cnt_nxt = CNT_INIT;
          end
        end

        ST_MULDIV: begin
          MulDivBusy = 1'b1;
          if (PCSrc_MEM) begin
            // The older branch in MEM kills the mult/div along with the rest.
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            EXMEM_Bubble = 1'b1;
            state_nxt    = ST_RUN;
            busy_cnt_nxt = '0;
          end else if (busy_cnt == '0) begin
            // Final EX cycle: let the result into EX/MEM and release the
            // front end in the same cycle.
            state_nxt = ST_RUN;
          end else begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEM_Bubble = 1'b1;
            busy_cnt_nxt = busy_cnt - CNT_W'(1);
          end
        end

        default: begin
          state_nxt    = ST_RUN;
          busy_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, occupancy counter and stall statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_RUN;
      busy_cnt   <= '0;
      StallCount <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      if (!PCWrite && !stall_sat) begin
        StallCount <= StallCount + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  localparam int LAT = 4;
  localparam int SCW = 4;

  // {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble,
  //  IFID_Flush, IDEX_Flush, EXMEM_Bubble, MulDivBusy}
  localparam logic [7:0] O_NORM   = 8'b1110_0000;
  localparam logic [7:0] O_STALL  = 8'b0011_0000;
  localparam logic [7:0] O_FLUSH  = 8'b1110_1110;
  localparam logic [7:0] O_FLMD   = 8'b1110_1111;
  localparam logic [7:0] O_MDHOLD = 8'b0000_0011;
  localparam logic [7:0] O_MDLAST = 8'b1110_0001;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic [4:0]     rs_ID = '0, rt_ID = '0;
  logic           UsesRt_ID = 1'b0, JR_ID = 1'b0, MulDiv_ID = 1'b0;
  logic           MemRead_IDEX = 1'b0;
  logic [4:0]     rt_IDEX = '0;
  logic           RegWrite_EX = 1'b0;
  logic [4:0]     WriteReg_EX = '0;
  logic           RegWrite_MEM = 1'b0;
  logic [4:0]     WriteReg_MEM = '0;
  logic           PCSrc_MEM = 1'b0;
  logic           PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble;
  logic           IFID_Flush, IDEX_Flush, EXMEM_Bubble, MulDivBusy;
  logic [SCW-1:0] StallCount;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  hazard_controller #(.MULDIV_LAT(LAT), .STALL_CNT_W(SCW)) dut (
    .Clk(Clk), .Rst(Rst),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .UsesRt_ID(UsesRt_ID), .JR_ID(JR_ID),
    .MulDiv_ID(MulDiv_ID), .MemRead_IDEX(MemRead_IDEX), .rt_IDEX(rt_IDEX),
    .RegWrite_EX(RegWrite_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_MEM(RegWrite_MEM), .WriteReg_MEM(WriteReg_MEM),
    .PCSrc_MEM(PCSrc_MEM),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Bubble(EXMEM_Bubble), .MulDivBusy(MulDivBusy), .StallCount(StallCount)
  );

  typedef struct {
    string          name;
    logic           rst;
    logic [4:0]     rs, rt;
    logic           uses_rt, jr, muldiv, memread;
    logic [4:0]     rt_idex;
    logic           rw_ex;
    logic [4:0]     wr_ex;
    logic           rw_mem;
    logic [4:0]     wr_mem;
    logic           pcsrc;
    logic [7:0]     exp_out;
    logic [SCW-1:0] exp_cnt;
  } vec_t;

  function automatic vec_t base(string name, logic [7:0] e, int c);
    vec_t v;
    v.name = name;  v.rst = 1'b0;
    v.rs = '0;  v.rt = '0;  v.uses_rt = 1'b0;  v.jr = 1'b0;
    v.muldiv = 1'b0;  v.memread = 1'b0;  v.rt_idex = '0;
    v.rw_ex = 1'b0;  v.wr_ex = '0;  v.rw_mem = 1'b0;  v.wr_mem = '0;
    v.pcsrc = 1'b0;  v.exp_out = e;  v.exp_cnt = SCW'(c);
    return v;
  endfunction

  function automatic vec_t lu(vec_t v);
    vec_t r = v;
    r.memread = 1'b1;  r.rt_idex = 5'd2;  r.rs = 5'd2;
    return r;
  endfunction

  // Drive one cycle's inputs after the falling edge, check the combinational
  // outputs and the current StallCount before the next rising edge.
  task automatic apply(input vec_t v);
    logic [7:0] got;
    @(negedge Clk);
    Rst = v.rst;  rs_ID = v.rs;  rt_ID = v.rt;  UsesRt_ID = v.uses_rt;
    JR_ID = v.jr;  MulDiv_ID = v.muldiv;  MemRead_IDEX = v.memread;
    rt_IDEX = v.rt_idex;  RegWrite_EX = v.rw_ex;  WriteReg_EX = v.wr_ex;
    RegWrite_MEM = v.rw_mem;  WriteReg_MEM = v.wr_mem;  PCSrc_MEM = v.pcsrc;
    #1;
    got = {PCWrite, IFIDWrite, IDEXWrite, IDEX_Bubble,
           IFID_Flush, IDEX_Flush, EXMEM_Bubble, MulDivBusy};
    n_vec++;
    if (got !== v.exp_out || StallCount !== v.exp_cnt) begin
      n_bad++;
      $display("FAIL %s: outputs got %b want %b, StallCount got %0d want %0d",
               v.name, got, v.exp_out, StallCount, v.exp_cnt);
    end
  endtask

  vec_t vq[$];
  vec_t v;

  initial begin
    // ---------------- table-driven vectors ----------------
    v = lu(base("reset_forces_outputs", O_NORM, 0)); v.rst = 1'b1; vq.push_back(v);
    v = base("reset_hold", O_NORM, 0); v.rst = 1'b1; vq.push_back(v);
    vq.push_back(base("idle_after_reset", O_NORM, 0));
    vq.push_back(lu(base("lu_rs_stall", O_STALL, 0)));
    vq.push_back(base("lu_released", O_NORM, 1));
    v = base("lu_rt_stall", O_STALL, 1);
    v.memread = 1; v.rt_idex = 5'd7; v.rt = 5'd7; v.uses_rt = 1; v.rs = 5'd3;
    vq.push_back(v);
    v.name = "rt_match_unused"; v.uses_rt = 0; v.exp_out = O_NORM; v.exp_cnt = 2;
    vq.push_back(v);
    v = base("lw_to_r0_no_stall", O_NORM, 2); v.memread = 1; vq.push_back(v);
    v = base("jh_ex_match", O_STALL, 2); v.jr = 1; v.rs = 5'd5;
    v.rw_ex = 1; v.wr_ex = 5'd5; vq.push_back(v);
    v = base("jh_mem_match", O_STALL, 3); v.jr = 1; v.rs = 5'd5;
    v.rw_mem = 1; v.wr_mem = 5'd5; vq.push_back(v);
    v = base("jr_proceeds", O_NORM, 4); v.jr = 1; v.rs = 5'd5; vq.push_back(v);
    v = base("jr_r0_no_stall", O_NORM, 4); v.jr = 1; v.rw_ex = 1; vq.push_back(v);
    v = base("jr_no_regwrite", O_NORM, 4); v.jr = 1; v.rs = 5'd5;
    v.wr_ex = 5'd5; v.wr_mem = 5'd5; vq.push_back(v);
    v = lu(base("branch_over_lu", O_FLUSH, 4)); v.pcsrc = 1; vq.push_back(v);
    v = base("branch_kills_muldiv", O_FLUSH, 4); v.pcsrc = 1; v.muldiv = 1;
    vq.push_back(v);
    vq.push_back(base("no_muldiv_after_branch", O_NORM, 4));
    v = base("muldiv_enter", O_NORM, 4); v.muldiv = 1; vq.push_back(v);
    vq.push_back(base("muldiv_hold1", O_MDHOLD, 4));
    vq.push_back(lu(base("muldiv_hold2_ignores_lu", O_MDHOLD, 5)));
    vq.push_back(base("muldiv_last", O_MDLAST, 6));
    vq.push_back(lu(base("lu_after_muldiv", O_STALL, 6)));
    vq.push_back(base("idle_after_lu", O_NORM, 7));

    foreach (vq[i]) apply(vq[i]);

    // ---------------- branch resolves on first MULDIV cycle ----------------
    v = base("md_br_enter", O_NORM, 7); v.muldiv = 1; apply(v);
    v = base("md_br_flush", O_FLMD, 7); v.pcsrc = 1; apply(v);
    apply(base("md_br_back_to_run", O_NORM, 7));
    apply(base("md_br_no_residual", O_NORM, 7));

    // ---------------- reset on second MULDIV cycle ----------------
    v = base("md_rst_enter", O_NORM, 7); v.muldiv = 1; apply(v);
    apply(base("md_rst_hold1", O_MDHOLD, 7));
    v = base("md_rst_forced", O_NORM, 8); v.rst = 1; apply(v);
    apply(base("md_rst_run", O_NORM, 0));
    apply(base("md_rst_run2", O_NORM, 0));

    // ---------------- StallCount saturation ----------------
    for (int i = 0; i < 18; i++) begin
      apply(lu(base("stall_sat", O_STALL, (i > 15) ? 15 : i)));
      apply(base("stall_sat_gap", O_NORM, (i + 1 > 15) ? 15 : i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
